// File: rtl/pdm_demodulator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pdm_demodulator_pkg
// Brief    : Shared defaults and size helpers for the PDM demodulator.
// Revision : 1.0 - initial release
// ============================================================================
package pdm_demodulator_pkg;

    localparam int c_DEF_LOG2_WIN    = 5;
    localparam int c_DEF_OUT_W       = 5;
    localparam int c_DEF_SYNC_STAGES = 2;

    function automatic int win_size(input int log2_win);
        return 1 << log2_win;
    endfunction

    // One extra bit so a full window of ones (count == WIN) is representable.
    function automatic int cnt_width(input int log2_win);
        return log2_win + 1;
    endfunction

    function automatic int sat_max(input int out_w);
        return (1 << out_w) - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pdm_sync_chain.sv
`default_nettype none
// ============================================================================
// Module   : pdm_sync_chain
// Brief    : STAGES-deep single-bit synchroniser, async reset to 0.
// Revision : 1.0 - initial release
// ============================================================================
module pdm_sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], d};
        end
    end

    assign q = r_chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/pdm_demodulator.sv
`default_nettype none
// ============================================================================
// Module   : pdm_demodulator
// Brief    : Integrate-and-dump decimator turning a 1-bit PDM stream into one
//            OUT_W-bit sample per 2**LOG2_WIN accepted bits.
// Revision : 1.0 - initial release
// ============================================================================
module pdm_demodulator
    import pdm_demodulator_pkg::*;
#(
    parameter int LOG2_WIN    = c_DEF_LOG2_WIN,
    parameter int OUT_W       = c_DEF_OUT_W,
    parameter int SYNC_STAGES = c_DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pdm_in,
    input  logic             sample_en,
    input  logic             en,
    output logic [OUT_W-1:0] data_out,
    output logic             data_valid,
    output logic             sat
);

    localparam int c_WIN   = win_size(LOG2_WIN);
    localparam int c_CNT_W = cnt_width(LOG2_WIN);
    localparam int c_SAT   = sat_max(OUT_W);
    localparam int c_EXT_W = (c_CNT_W > OUT_W) ? c_CNT_W : OUT_W;

    localparam logic [c_EXT_W-1:0]  c_SAT_MAX = c_EXT_W'(c_SAT);
    localparam logic [LOG2_WIN-1:0] c_LAST    = LOG2_WIN'(c_WIN - 1);

    logic                w_pdm_s;
    logic                w_accept;
    logic                w_dump;
    logic                w_sat;
    logic [c_CNT_W-1:0]  w_total;
    logic [c_EXT_W-1:0]  w_total_ext;

    logic [c_CNT_W-1:0]  r_ones_cnt;
    logic [LOG2_WIN-1:0] r_samp_cnt;
    logic [OUT_W-1:0]    r_data_out;
    logic                r_data_valid;
    logic                r_sat;

    pdm_sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pdm_in),
        .q     (w_pdm_s)
    );

    assign w_accept    = en && sample_en;
    assign w_dump      = w_accept && (r_samp_cnt == c_LAST);
    assign w_total     = r_ones_cnt + c_CNT_W'(w_pdm_s);
    // Compare in a width wide enough for both the count and the clip level.
    assign w_total_ext = c_EXT_W'(w_total);
    assign w_sat       = (w_total_ext > c_SAT_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ones_cnt   <= '0;
            r_samp_cnt   <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_sat        <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            if (!en) begin
                r_ones_cnt <= '0;
                r_samp_cnt <= '0;
            end else if (w_dump) begin
                r_data_out   <= w_sat ? OUT_W'(c_SAT_MAX) : OUT_W'(w_total_ext);
                r_sat        <= w_sat;
                r_data_valid <= 1'b1;
                r_ones_cnt   <= '0;
                r_samp_cnt   <= '0;
            end else if (w_accept) begin
                r_ones_cnt <= w_total;
                r_samp_cnt <= r_samp_cnt + 1'b1;
            end
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign sat        = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_pdm_demodulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_pdm_demodulator
// Brief    : Directed self-checking bench for pdm_demodulator (32-bit window).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pdm_demodulator;

    logic       clk = 1'b0;
    logic       reset;
    logic       pdm_in;
    logic       sample_en;
    logic       en;
    logic [4:0] data_out;
    logic       data_valid;
    logic       sat;

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus generator state: constant level or first-order modulator.
    int         mode;
    logic       const_bit;
    int         code;
    logic [4:0] mod_acc;
    logic       mod_bit;
    int         gap;
    int         phase;
    logic       en_val;

    pdm_demodulator #(
        .LOG2_WIN    (5),
        .OUT_W       (5),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pdm_in     (pdm_in),
        .sample_en  (sample_en),
        .en         (en),
        .data_out   (data_out),
        .data_valid (data_valid),
        .sat        (sat)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // The modulator advances once per gap group; the strobe lands two calls
    // later so it samples exactly that group's bit through the 2-flop sync.
    task automatic tick();
        logic [5:0] sum;
        if (phase == 0) begin
            sum     = {1'b0, mod_acc} + 6'(code);
            mod_acc = sum[4:0];
            mod_bit = sum[5];
        end
        pdm_in    = (mode == 0) ? const_bit : mod_bit;
        sample_en = (phase == gap - 1);
        en        = en_val;
        phase     = (phase == gap - 1) ? 0 : phase + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!data_valid && n < max);
        check_eq("valid_seen", 32'(data_valid), 1);
    endtask

    task automatic start_mod(input int c, input int g);
        mode    = 1;
        code    = c;
        mod_acc = '0;
        gap     = g;
        phase   = 0;
    endtask

    initial begin
        int n;
        int vcount;

        reset     = 1'b1;
        mode      = 0;
        const_bit = 1'b1;
        code      = 0;
        mod_acc   = '0;
        mod_bit   = 1'b0;
        gap       = 1;
        phase     = 0;
        en_val    = 1'b1;
        pdm_in    = 1'b1;
        sample_en = 1'b1;
        en        = 1'b1;

        // Reset held while the stream runs
        repeat (4) tick();
        check_eq("rst_data_out", 32'(data_out), 0);
        check_eq("rst_data_valid", 32'(data_valid), 0);
        check_eq("rst_sat", 32'(sat), 0);

        // First window after release: two sync-chain zeros then ones
        reset  = 1'b0;
        vcount = 0;
        for (int i = 0; i < 31; i++) begin
            tick();
            if (data_valid) vcount++;
        end
        check_eq("first_win_early_valid", 32'(vcount), 0);
        tick();
        check_eq("first_win_valid", 32'(data_valid), 1);
        check_eq("first_win_data", 32'(data_out), 30);
        check_eq("first_win_sat", 32'(sat), 0);
        tick();
        check_eq("valid_one_cycle", 32'(data_valid), 0);

        // All ones saturates; then zeros drain to 0
        wait_valid(40, n);
        check_eq("ones_period", 32'(n), 31);
        check_eq("ones_data", 32'(data_out), 31);
        check_eq("ones_sat", 32'(sat), 1);
        const_bit = 1'b0;
        wait_valid(40, n);
        check_eq("drain_data", 32'(data_out), 2);
        check_eq("drain_sat", 32'(sat), 0);
        wait_valid(40, n);
        check_eq("zeros_data", 32'(data_out), 0);
        check_eq("zeros_sat", 32'(sat), 0);

        // Continuous modulator stream, code 10
        start_mod(10, 1);
        wait_valid(40, n);
        for (int k = 0; k < 3; k++) begin
            wait_valid(40, n);
            check_eq("code10_period", 32'(n), 32);
            check_eq("code10_data", 32'(data_out), 10);
            check_eq("code10_sat", 32'(sat), 0);
        end

        // Gapped stream, strobe every third clock, code 7
        start_mod(7, 3);
        wait_valid(200, n);
        for (int k = 0; k < 2; k++) begin
            wait_valid(200, n);
            check_eq("gap_period", 32'(n), 96);
            check_eq("gap_data", 32'(data_out), 7);
            check_eq("gap_sat", 32'(sat), 0);
        end

        // Drop enable mid-window, then restart with a different code
        start_mod(10, 1);
        wait_valid(40, n);
        wait_valid(40, n);
        check_eq("pre_en_data", 32'(data_out), 10);
        repeat (20) tick();
        start_mod(20, 1);
        en_val = 1'b0;
        vcount = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (data_valid) vcount++;
        end
        check_eq("en_low_valid", 32'(vcount), 0);
        check_eq("en_low_hold", 32'(data_out), 10);
        en_val = 1'b1;
        vcount = 0;
        for (int i = 0; i < 31; i++) begin
            tick();
            if (data_valid) vcount++;
        end
        check_eq("reen_early_valid", 32'(vcount), 0);
        check_eq("reen_hold", 32'(data_out), 10);
        tick();
        check_eq("reen_valid", 32'(data_valid), 1);
        check_eq("reen_data", 32'(data_out), 20);

        // Code sweep with the window aligned to the modulator start
        for (int c = 0; c < 32; c++) begin
            start_mod(c, 1);
            en_val = 1'b0;
            repeat (2) tick();
            en_val = 1'b1;
            vcount = 0;
            for (int i = 0; i < 31; i++) begin
                tick();
                if (data_valid) vcount++;
            end
            tick();
            check_eq("sweep_early_valid", 32'(vcount), 0);
            check_eq("sweep_valid", 32'(data_valid), 1);
            check_eq("sweep_data", 32'(data_out), 32'(c));
            check_eq("sweep_sat", 32'(sat), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
